// File: rtl/change_dispenser.sv
// Greedy coin payout stage: takes a change amount and pays it out one coin at a time to a hopper.
// Optional per-denomination stock tracking and shortfall reporting via `define INVENTORY_EN.
module change_dispenser #(
  parameter int unsigned INIT_STOCK = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] change_in,
  input  logic       change_valid,
  output logic       change_ready,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic       done,
  output logic [7:0] coin_count,
  output logic [7:0] short_amt,
  input  logic       refill
);

  typedef enum logic [1:0] {
    StIdle,
    StDispense,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] count_q, count_d;

  logic [3:0] stock_ok;
  logic [1:0] sel;
  logic       sel_found;
  logic       coin_fire;

  function automatic logic [7:0] denom(input logic [1:0] s);
    logic [7:0] v;
    unique case (s)
      2'd0:    v = 8'd20;
      2'd1:    v = 8'd10;
      2'd2:    v = 8'd5;
      default: v = 8'd1;
    endcase
    return v;
  endfunction

  // Scan smallest-to-largest so the largest eligible denomination is the last one kept.
  always_comb begin
    sel       = 2'd0;
    sel_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (denom(2'(i)) <= remaining_q && stock_ok[i]) begin
        sel       = 2'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign change_ready = (state_q == StIdle);
  assign coin_valid   = (state_q == StDispense) && sel_found;
  assign coin_sel     = coin_valid ? sel : 2'd0;
  assign done         = (state_q == StDone);
  assign coin_count   = count_q;
  assign coin_fire    = coin_valid && coin_ack;

`ifdef INVENTORY_EN
  logic [7:0] stock_q [4];
  logic [7:0] stock_d [4];
  logic [7:0] short_q, short_d;

  for (genvar g = 0; g < 4; g++) begin : g_stock_ok
    assign stock_ok[g] = (stock_q[g] != 8'd0);
  end

  // Refill lands on the same edge as an accept, so the new transaction sees full stock.
  always_comb begin
    stock_d = stock_q;
    if (state_q == StIdle && refill) begin
      for (int i = 0; i < 4; i++) begin
        stock_d[i] = 8'(INIT_STOCK);
      end
    end else if (coin_fire) begin
      stock_d[sel] = stock_q[sel] - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= 8'(INIT_STOCK);
      end
      short_q <= 8'd0;
    end else begin
      stock_q <= stock_d;
      short_q <= short_d;
    end
  end

  assign short_amt = short_q;
`else
  logic       unused_refill;
  logic [7:0] unused_init_stock;

  assign stock_ok          = 4'b1111;
  assign short_amt         = 8'd0;
  assign unused_refill     = refill;
  assign unused_init_stock = 8'(INIT_STOCK);
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
`ifdef INVENTORY_EN
    short_d     = short_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (change_valid) begin
          remaining_d = change_in;
          count_d     = 8'd0;
`ifdef INVENTORY_EN
          short_d     = 8'd0;
`endif
          state_d     = (change_in == 8'd0) ? StDone : StDispense;
        end
      end
      StDispense: begin
        if (sel_found) begin
          if (coin_ack) begin
            remaining_d = remaining_q - denom(sel);
            count_d     = (count_q == 8'hff) ? count_q : count_q + 8'd1;
            if (remaining_d == 8'd0) begin
              state_d = StDone;
            end
          end
        end else begin
          // Nothing fits the remaining amount with the stock left: give up on the rest.
`ifdef INVENTORY_EN
          short_d = remaining_q;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= 8'd0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine controller. Accepts the 8-bit change amount the controller computes after a sale and pays it out one coin at a time to a coin hopper, greedy largest-denomination-first, using a valid/ack handshake. Reports a per-transaction coin count and a completion pulse. Optionally tracks per-denomination stock and reports any shortfall.

## Interface
Parameters:
- INIT_STOCK, 15: coins of each denomination loaded at reset or refill. Used only with INVENTORY_EN.

Ports:
- clk: input, 1 bit. Single clock; all logic on the rising edge.
- rst: input, 1 bit. Synchronous, active-high reset.
- change_in: input, 8 bits. Change amount in units, 0–255.
- change_valid: input, 1 bit. change_in is valid.
- change_ready: output, 1 bit. High only in IDLE.
- coin_valid: output, 1 bit. A coin request is presented to the hopper.
- coin_sel: output, 2 bits. Coin denomination:
  - 0 = 20
  - 1 = 10
  - 2 = 5
  - 3 = 1
- coin_ack: input, 1 bit. Hopper has released the presented coin.
- done: output, 1 bit. One-cycle pulse when the transaction ends.
- coin_count: output, 8 bits. Coins paid in the current or last transaction.
- short_amt: output, 8 bits. Unpaid remainder. Always 0 without INVENTORY_EN.
- refill: input, 1 bit. Reload stock. Used only with INVENTORY_EN.

## Operation
- States: IDLE, DISPENSE, DONE. Internal 8-bit register `remaining`.
- Values after reset:
  - State IDLE, remaining 0.
  - change_ready 1.
  - coin_valid 0, coin_sel 0, done 0, coin_count 0, short_amt 0.
  - Stock = INIT_STOCK for each denomination.
- IDLE:
  - When change_valid is high, load `remaining` = change_in and clear coin_count and short_amt.
  - If change_in is 0, go to DONE. Otherwise go to DISPENSE.
- DISPENSE:
  - coin_sel = largest denomination d with d ≤ remaining (and stock[d] > 0 under INVENTORY_EN).
  - coin_valid stays high, and coin_sel stays stable, until coin_ack arrives.
  - On the coin_ack cycle:
    - remaining -= d.
    - coin_count += 1, saturating at 255.
    - stock[d] -= 1.
  - If remaining becomes 0, go to DONE.
  - With INVENTORY_EN, if no denomination is eligible (all fitting denominations have zero stock), go to DONE with short_amt = remaining. No coin is requested.
- DONE:
  - done = 1 for exactly one cycle; coin_valid 0.
  - Next state is IDLE.
- coin_ack is ignored while coin_valid is 0.
- change_valid is ignored outside IDLE.
- refill is honoured only in IDLE; it is ignored in other states.
- Arithmetic:
  - remaining never underflows, because d ≤ remaining is guaranteed.
  - coin_count and short_amt keep their values until the next accept.

## Timing
- Accept at cycle N (change_valid & change_ready) → coin_valid high with a valid coin_sel at N+1.
- Zero amount accepted at N → done at N+1, change_ready at N+2.
- coin_ack at cycle M:
  - If remaining is still nonzero, the next coin is presented at M+1 and coin_valid stays high with no gap.
  - If remaining reaches 0, coin_valid is low and done is high at M+1, and change_ready is high at M+2.
- Shortfall detection costs one cycle: DISPENSE → DONE with coin_valid low.
- Reset mid-transaction: on the next edge, all outputs return to their reset values and the remaining amount is discarded. No done pulse is produced.
- rst and change_valid in the same cycle: rst wins.
- refill and change_valid in the same IDLE cycle: both take effect. Stock is reloaded first, so the new transaction sees the refilled stock.

## Configuration
- INVENTORY_EN defined:
  - Four 8-bit stock counters are present.
  - refill reloads them to INIT_STOCK.
  - Denominations with zero stock are skipped.
  - short_amt reports the unpaid remainder.
- INVENTORY_EN undefined:
  - No stock counters exist; supply is unlimited.
  - refill is ignored.
  - short_amt is tied to 0.
  - A transaction always pays change_in in full.

## Test plan
- change_in=38, coin_ack asserted in the same cycle as each coin_valid → coin_sel sequence 0,1,2,3,3,3; coin_count=6; done one cycle after the last ack.
- change_in=0 → no coin_valid; done at accept+1; coin_count=0; change_ready back at accept+2.
- change_in=25, coin_ack delayed 3 cycles per coin → coin_valid and coin_sel stable while waiting; sequence 0,2; coin_count=2.
- change_in=255, no INVENTORY_EN → twelve coins of sel 0, then sel 1, then sel 2; coin_count=14; short_amt=0.
- rst pulsed after the second ack of change_in=38 → next cycle coin_valid=0, change_ready=1, coin_count=0, no done; a new change_in=5 then yields a single coin with sel 2.
- INVENTORY_EN with INIT_STOCK=1, change_in=45 → sel 0,1,2,3, then done with short_amt=9 and coin_count=4. After refill, change_in=1 → sel 3.
